pll_lock_mgr: RTL

Lock supervisor and phase-step sequencer for the on-chip PLL. Drives the PLL reset, qualifies `pll_lock` into a stable `clk_ready_o` and a downstream core reset, retries on lock timeout, and converts a simple request/acknowledge into correctly timed dynamic phase-step pulses. Runs on the PLL input reference clock (50 MHz board clock), so it keeps working while PLL outputs are invalid.

---
 rtl/pll_lock_mgr.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_mgr.sv
// pll_lock_mgr: PLL lock supervisor with retry/fail handling and a
// request/acknowledge phase-step sequencer. Runs on the PLL reference clock.
module pll_lock_mgr #(
   parameter int unsigned RST_PULSE_CYCLES    = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
   parameter int unsigned MAX_RETRY           = 3,
   parameter int unsigned PHASE_STEP_GAP      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_lock_i,
   output logic       pll_rst_o,
   output logic       clk_ready_o,
   output logic       sys_rst_o,
   output logic       fail_o,
   output logic [3:0] retry_cnt_o,
   input  logic       ps_req_i,
   input  logic       ps_dir_i,
   input  logic [2:0] ps_sel_i,
   output logic       ps_ack_o,
   output logic       ps_busy_o,
   output logic [2:0] phase_sel_o,
   output logic       phase_dir_o,
   output logic       phase_step_n_o
);

   localparam int unsigned RST_W = $clog2(RST_PULSE_CYCLES + 1);
   localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int unsigned GAP_W = $clog2(PHASE_STEP_GAP + 1);

   typedef enum logic [2:0] {
      SUP_RESET,
      SUP_WAIT_LOCK,
      SUP_STABLE,
      SUP_READY,
      SUP_FAIL
   } sup_state_e;

   typedef enum logic [1:0] {
      PS_IDLE,
      PS_SETUP,
      PS_STROBE,
      PS_GAP
   } ps_state_e;

   // Lock synchronizer
   logic lock_meta_q, lock_sync_q;

   // Supervisor state
   sup_state_e       sup_q, sup_d;
   logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
   logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
   logic [STB_W-1:0] stb_next_c;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [3:0]       retry_q, retry_d;
   logic             pll_rst_q, clk_ready_q, sys_rst_q, fail_q;

   // Phase-step state
   ps_state_e        ps_q, ps_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [2:0]       sel_q, sel_d;
   logic             dir_q, dir_d;
   logic             ack_q, ack_d;
   logic             busy_q, step_n_q;
   logic             ready_hold_c;

   // Two-flop synchronizer for the asynchronous lock input
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
      end else begin
         lock_meta_q <= pll_lock_i;
         lock_sync_q <= lock_meta_q;
      end
   end

   // Supervisor state, counters and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sup_q       <= SUP_RESET;
         rst_cnt_q   <= '0;
         stb_cnt_q   <= '0;
         to_cnt_q    <= '0;
         retry_q     <= '0;
         pll_rst_q   <= 1'b1;
         clk_ready_q <= 1'b0;
         sys_rst_q   <= 1'b1;
         fail_q      <= 1'b0;
      end else begin
         sup_q       <= sup_d;
         rst_cnt_q   <= rst_cnt_d;
         stb_cnt_q   <= stb_cnt_d;
         to_cnt_q    <= to_cnt_d;
         retry_q     <= retry_d;
         pll_rst_q   <= (sup_d == SUP_RESET) || (sup_d == SUP_FAIL);
         clk_ready_q <= (sup_d == SUP_READY);
         sys_rst_q   <= (sup_d != SUP_READY);
         fail_q      <= (sup_d == SUP_FAIL);
      end
   end

   // Supervisor next-state: reset pulse, lock qualification, timeout/retry
   always_comb begin
      sup_d      = sup_q;
      rst_cnt_d  = rst_cnt_q;
      stb_cnt_d  = stb_cnt_q;
      to_cnt_d   = to_cnt_q;
      retry_d    = retry_q;
      stb_next_c = '0;

      case (sup_q)
         SUP_RESET: begin
            to_cnt_d  = '0;
            stb_cnt_d = '0;
            if (rst_cnt_q == RST_W'(RST_PULSE_CYCLES - 1)) begin
               rst_cnt_d = '0;
               sup_d     = SUP_WAIT_LOCK;
            end else begin
               rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
         end

         SUP_WAIT_LOCK, SUP_STABLE: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            // Timeout wins over a lock-stable completion in the same cycle
            if (to_cnt_q == TO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
               stb_cnt_d = '0;
               if (retry_q == 4'(MAX_RETRY)) begin
                  sup_d = SUP_FAIL;
               end else begin
                  retry_d = retry_q + 4'd1;
                  sup_d   = SUP_RESET;
               end
            end else if (!lock_sync_q) begin
               stb_cnt_d = '0;
               sup_d     = SUP_WAIT_LOCK;
            end else begin
               stb_next_c = (sup_q == SUP_WAIT_LOCK) ? STB_W'(1) : stb_cnt_q + STB_W'(1);
               if (stb_next_c == STB_W'(LOCK_STABLE_CYCLES)) begin
                  stb_cnt_d = '0;
                  retry_d   = '0;
                  sup_d     = SUP_READY;
               end else begin
                  stb_cnt_d = stb_next_c;
                  sup_d     = SUP_STABLE;
               end
            end
         end

         SUP_READY: begin
            if (!lock_sync_q) begin
               rst_cnt_d = '0;
               sup_d     = SUP_RESET;
            end
         end

         SUP_FAIL: begin
            sup_d = SUP_FAIL;
         end

         default: begin
            rst_cnt_d = '0;
            sup_d     = SUP_RESET;
         end
      endcase
   end

   // Phase-step state and registered PLL phase controls
   always_ff @(posedge clk) begin
      if (rst) begin
         ps_q     <= PS_IDLE;
         gap_q    <= '0;
         sel_q    <= '0;
         dir_q    <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         step_n_q <= 1'b1;
      end else begin
         ps_q     <= ps_d;
         gap_q    <= gap_d;
         sel_q    <= sel_d;
         dir_q    <= dir_d;
         ack_q    <= ack_d;
         busy_q   <= (ps_d != PS_IDLE);
         step_n_q <= (ps_d != PS_STROBE);
      end
   end

   // Phase-step next-state; any exit from READY aborts the step silently
   always_comb begin
      ps_d         = ps_q;
      gap_d        = gap_q;
      sel_d        = sel_q;
      dir_d        = dir_q;
      ack_d        = 1'b0;
      ready_hold_c = (sup_q == SUP_READY) && (sup_d == SUP_READY);

      if (!ready_hold_c) begin
         ps_d  = PS_IDLE;
         gap_d = '0;
      end else begin
         case (ps_q)
            PS_IDLE: begin
               if (ps_req_i && !ack_q) begin
                  sel_d = ps_sel_i;
                  dir_d = ps_dir_i;
                  ps_d  = PS_SETUP;
               end
            end
            PS_SETUP: begin
               ps_d = PS_STROBE;
            end
            PS_STROBE: begin
               gap_d = '0;
               ps_d  = PS_GAP;
            end
            PS_GAP: begin
               if (gap_q == GAP_W'(PHASE_STEP_GAP - 1)) begin
                  gap_d = '0;
                  ack_d = 1'b1;
                  ps_d  = PS_IDLE;
               end else begin
                  gap_d = gap_q + GAP_W'(1);
               end
            end
            default: begin
               ps_d = PS_IDLE;
            end
         endcase
      end
   end

   assign pll_rst_o      = pll_rst_q;
   assign clk_ready_o    = clk_ready_q;
   assign sys_rst_o      = sys_rst_q;
   assign fail_o         = fail_q;
   assign retry_cnt_o    = retry_q;
   assign ps_ack_o       = ack_q;
   assign ps_busy_o      = busy_q;
   assign phase_sel_o    = sel_q;
   assign phase_dir_o    = dir_q;
   assign phase_step_n_o = step_n_q;

endmodule
